// File: rtl/xadac_id_alloc_pkg.sv
// Shared types for the XADAC transaction-ID allocator: ID width, the
// per-ID lifecycle state, and the payload carried on every channel.
package xadac_id_alloc_pkg;

   localparam int SbLen = 8;
   localparam int IdW   = (SbLen > 1) ? $clog2(SbLen) : 1;

   typedef logic [IdW-1:0] IdT;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      DEC  = 2'd1,
      RDY  = 2'd2,
      EXE  = 2'd3
   } IdStateT;

   typedef struct packed {
      IdT          id;
      logic [31:0] data;
   } XadacPktT;

endpackage

// File: rtl/xadac_id_alloc_if.sv
// Core <-> fabric XADAC link: decode and execute request/response channels,
// each a valid/ready handshake. The mst side issues requests and accepts
// responses; the slv side does the opposite.
interface xadac_if;
   import xadac_id_alloc_pkg::*;

   XadacPktT dec_req;
   logic     dec_req_valid;
   logic     dec_req_ready;
   XadacPktT dec_rsp;
   logic     dec_rsp_valid;
   logic     dec_rsp_ready;
   XadacPktT exe_req;
   logic     exe_req_valid;
   logic     exe_req_ready;
   XadacPktT exe_rsp;
   logic     exe_rsp_valid;
   logic     exe_rsp_ready;

   modport mst (
      output dec_req, dec_req_valid, input  dec_req_ready,
      input  dec_rsp, dec_rsp_valid, output dec_rsp_ready,
      output exe_req, exe_req_valid, input  exe_req_ready,
      input  exe_rsp, exe_rsp_valid, output exe_rsp_ready
   );

   modport slv (
      input  dec_req, dec_req_valid, output dec_req_ready,
      output dec_rsp, dec_rsp_valid, input  dec_rsp_ready,
      input  exe_req, exe_req_valid, output exe_req_ready,
      output exe_rsp, exe_rsp_valid, input  exe_rsp_ready
   );
endinterface

// File: rtl/xadac_id_alloc_ffs.sv
// Find-first-set: reports the lowest set bit of req and whether any bit is set.
module xadac_ffs #(
   parameter int Width = 4,
   parameter int IdxW  = 2
) (
   input  logic [Width-1:0] req,
   output logic [IdxW-1:0]  idx,
   output logic             found
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = Width - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IdxW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xadac_id_alloc.sv
// Transaction-ID allocator between the core and the XADAC mux. Stamps each
// decode request with the lowest free ID, walks every ID through
// FREE->DEC->RDY->EXE->FREE, holds execute requests for IDs not yet decoded,
// and pulses err_o for responses or requests that do not fit an ID's state.
module xadac_id_alloc
   import xadac_id_alloc_pkg::*;
#(
   parameter int NumId          = SbLen,
   parameter int MaxOutstanding = NumId
) (
   input  logic                       clk,
   input  logic                       rst,
   xadac_if.slv                       slv,
   xadac_if.mst                       mst,
   output logic [$clog2(NumId+1)-1:0] busy_o,
   output logic                       err_o
);

   localparam int BusyW = $clog2(NumId + 1);

   IdStateT           state_q [NumId];
   IdStateT           state_d [NumId];
   logic [BusyW-1:0]  busy_q, busy_d;
   logic              err_q, err_d;

   logic [NumId-1:0]  free_vec;
   IdT                alloc_id;
   logic              any_free, can_alloc;
   IdStateT           dec_rsp_st, exe_req_st, exe_rsp_st;

   logic              alloc_hs, dec_rsp_hs, exe_hs, exe_rsp_hs;
   logic              exe_fwd, exe_drop, drop_ev, free_hs;

   // Look up the current state of every ID referenced on the channels this
   // cycle; IDs beyond NumId read as FREE so they fall into the error paths.
   always_comb begin
      free_vec   = '0;
      dec_rsp_st = FREE;
      exe_req_st = FREE;
      exe_rsp_st = FREE;
      for (int i = 0; i < NumId; i++) begin
         free_vec[i] = (state_q[i] == FREE);
         if (mst.dec_rsp.id == IdT'(i)) dec_rsp_st = state_q[i];
         if (slv.exe_req.id == IdT'(i)) exe_req_st = state_q[i];
         if (mst.exe_rsp.id == IdT'(i)) exe_rsp_st = state_q[i];
      end
   end

   xadac_ffs #(
      .Width (NumId),
      .IdxW  (IdW)
   ) u_ffs (
      .req   (free_vec),
      .idx   (alloc_id),
      .found (any_free)
   );

   assign can_alloc = any_free && (int'(busy_q) < MaxOutstanding);

   assign mst.dec_req       = '{id: alloc_id, data: slv.dec_req.data};
   assign mst.dec_req_valid = !rst && slv.dec_req_valid && can_alloc;
   assign slv.dec_req_ready = !rst && mst.dec_req_ready && can_alloc;
   assign alloc_hs          = !rst && slv.dec_req_valid && mst.dec_req_ready && can_alloc;

   assign slv.dec_rsp       = mst.dec_rsp;
   assign slv.dec_rsp_valid = !rst && mst.dec_rsp_valid;
   assign mst.dec_rsp_ready = !rst && slv.dec_rsp_ready;
   assign dec_rsp_hs        = !rst && mst.dec_rsp_valid && slv.dec_rsp_ready;

   assign exe_fwd           = (exe_req_st == RDY);
   assign exe_drop          = (exe_req_st == FREE);
   assign mst.exe_req       = slv.exe_req;
   assign mst.exe_req_valid = !rst && slv.exe_req_valid && exe_fwd;
   assign slv.exe_req_ready = !rst && (exe_fwd ? mst.exe_req_ready : exe_drop);
   assign exe_hs            = !rst && slv.exe_req_valid && exe_fwd && mst.exe_req_ready;
   assign drop_ev           = !rst && slv.exe_req_valid && exe_drop;

   assign slv.exe_rsp       = mst.exe_rsp;
   assign slv.exe_rsp_valid = !rst && mst.exe_rsp_valid;
   assign mst.exe_rsp_ready = !rst && slv.exe_rsp_ready;
   assign exe_rsp_hs        = !rst && mst.exe_rsp_valid && slv.exe_rsp_ready;
   assign free_hs           = exe_rsp_hs && (exe_rsp_st == EXE);

   // Per-ID lifecycle transitions. Each transition requires a distinct
   // current state, so at most one can hit a given ID in a cycle.
   always_comb begin
      for (int i = 0; i < NumId; i++) begin
         state_d[i] = state_q[i];
      end
      for (int i = 0; i < NumId; i++) begin
         if (alloc_hs && alloc_id == IdT'(i)) begin
            state_d[i] = DEC;
         end
         if (dec_rsp_hs && dec_rsp_st == DEC && mst.dec_rsp.id == IdT'(i)) begin
            state_d[i] = RDY;
         end
         if (exe_hs && slv.exe_req.id == IdT'(i)) begin
            state_d[i] = EXE;
         end
         if (free_hs && mst.exe_rsp.id == IdT'(i)) begin
            state_d[i] = FREE;
         end
      end
   end

   // Occupancy count and the merged protocol-violation flag for this cycle.
   always_comb begin
      busy_d = busy_q + BusyW'(alloc_hs) - BusyW'(free_hs);
      err_d  = (dec_rsp_hs && dec_rsp_st != DEC)
             || drop_ev
             || (exe_rsp_hs && exe_rsp_st != EXE);
   end

   // State registers; reset abandons every in-flight ID immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumId; i++) begin
            state_q[i] <= FREE;
         end
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign busy_o = busy_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_xadac_id_alloc.sv
// Testbench for xadac_id_alloc with NumId=4, MaxOutstanding=4: directed
// lifecycle scenarios followed by randomized traffic against an ID-table model.
module tb_xadac_id_alloc;
   import xadac_id_alloc_pkg::*;

   localparam int N      = 4;
   localparam int M_FREE = 0;
   localparam int M_DEC  = 1;
   localparam int M_RDY  = 2;
   localparam int M_EXE  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] busy_o;
   logic       err_o;
   int         n_tests = 0;
   int         n_fail  = 0;

   xadac_if core_if ();
   xadac_if fab_if ();

   xadac_id_alloc #(.NumId(N), .MaxOutstanding(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .slv    (core_if),
      .mst    (fab_if),
      .busy_o (busy_o),
      .err_o  (err_o)
   );

   always #5 clk = ~clk;

   task automatic idle();
      core_if.dec_req       = '0;
      core_if.dec_req_valid = 1'b0;
      core_if.dec_rsp_ready = 1'b0;
      core_if.exe_req       = '0;
      core_if.exe_req_valid = 1'b0;
      core_if.exe_rsp_ready = 1'b0;
      fab_if.dec_req_ready  = 1'b0;
      fab_if.dec_rsp        = '0;
      fab_if.dec_rsp_valid  = 1'b0;
      fab_if.exe_req_ready  = 1'b0;
      fab_if.exe_rsp        = '0;
      fab_if.exe_rsp_valid  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc_n(input int n);
      core_if.dec_req_valid = 1'b1;
      fab_if.dec_req_ready  = 1'b1;
      for (int i = 0; i < n; i++) tick();
      idle();
   endtask

   task automatic send_dec_rsp(input int id);
      fab_if.dec_rsp        = '{id: IdT'(id), data: 32'h0};
      fab_if.dec_rsp_valid  = 1'b1;
      core_if.dec_rsp_ready = 1'b1;
      tick();
      idle();
   endtask

   task automatic send_exe_req(input int id);
      core_if.exe_req       = '{id: IdT'(id), data: 32'h0};
      core_if.exe_req_valid = 1'b1;
      fab_if.exe_req_ready  = 1'b1;
      tick();
      idle();
   endtask

   task automatic all_inputs_high();
      core_if.dec_req_valid = 1'b1;
      core_if.dec_rsp_ready = 1'b1;
      core_if.exe_req_valid = 1'b1;
      core_if.exe_rsp_ready = 1'b1;
      fab_if.dec_req_ready  = 1'b1;
      fab_if.dec_rsp_valid  = 1'b1;
      fab_if.exe_req_ready  = 1'b1;
      fab_if.exe_rsp_valid  = 1'b1;
   endtask

   function automatic logic [7:0] hs_outs();
      return {fab_if.dec_req_valid, core_if.dec_req_ready, core_if.dec_rsp_valid,
              fab_if.dec_rsp_ready, fab_if.exe_req_valid, core_if.exe_req_ready,
              core_if.exe_rsp_valid, fab_if.exe_rsp_ready};
   endfunction

   task automatic test_reset();
      idle();
      rst = 1'b1;
      all_inputs_high();
      #1;
      n_tests++;
      if (hs_outs() !== 8'h00) begin
         n_fail++; $display("[TB] FAIL reset_handshakes: got %b, want 00000000", hs_outs());
      end
      tick();
      n_tests++;
      if (busy_o !== 3'd0) begin
         n_fail++; $display("[TB] FAIL reset_busy: got %0d, want 0", busy_o);
      end
      n_tests++;
      if (err_o !== 1'b0) begin
         n_fail++; $display("[TB] FAIL reset_err: got %0d, want 0", err_o);
      end
      idle();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      do_reset();
      core_if.dec_req       = '{id: IdT'(7), data: 32'hABCD_0000};
      core_if.dec_req_valid = 1'b1;
      fab_if.dec_req_ready  = 1'b1;
      for (int i = 0; i < N; i++) begin
         #1;
         n_tests++;
         if (fab_if.dec_req_valid !== 1'b1 || int'(fab_if.dec_req.id) !== i ||
             core_if.dec_req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fill_alloc%0d: got valid=%0d id=%0d ready=%0d, want 1 %0d 1",
                     i, fab_if.dec_req_valid, fab_if.dec_req.id, core_if.dec_req_ready, i);
         end
         tick();
      end
      #1;
      n_tests++;
      if (core_if.dec_req_ready !== 1'b0 || fab_if.dec_req_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL fill_fifth_held: got ready=%0d valid=%0d, want 0 0",
                  core_if.dec_req_ready, fab_if.dec_req_valid);
      end
      n_tests++;
      if (busy_o !== 3'd4) begin
         n_fail++; $display("[TB] FAIL fill_busy: got %0d, want 4", busy_o);
      end
      idle();
   endtask

   task automatic test_full_cycle();
      do_reset();
      alloc_n(4);
      send_dec_rsp(2);
      n_tests++;
      if (err_o !== 1'b0) begin
         n_fail++; $display("[TB] FAIL cycle_dec_rsp_err: got %0d, want 0", err_o);
      end
      core_if.exe_req       = '{id: IdT'(2), data: 32'h1234};
      core_if.exe_req_valid = 1'b1;
      fab_if.exe_req_ready  = 1'b1;
      #1;
      n_tests++;
      if (fab_if.exe_req_valid !== 1'b1 || core_if.exe_req_ready !== 1'b1 ||
          fab_if.exe_req.id !== IdT'(2)) begin
         n_fail++;
         $display("[TB] FAIL cycle_exe_fwd: got valid=%0d ready=%0d id=%0d, want 1 1 2",
                  fab_if.exe_req_valid, core_if.exe_req_ready, fab_if.exe_req.id);
      end
      tick();
      idle();
      fab_if.exe_rsp        = '{id: IdT'(2), data: 32'h5678};
      fab_if.exe_rsp_valid  = 1'b1;
      core_if.exe_rsp_ready = 1'b1;
      #1;
      n_tests++;
      if (core_if.exe_rsp_valid !== 1'b1 || core_if.exe_rsp.data !== 32'h5678) begin
         n_fail++;
         $display("[TB] FAIL cycle_exe_rsp_pass: got valid=%0d data=%h, want 1 5678",
                  core_if.exe_rsp_valid, core_if.exe_rsp.data);
      end
      tick();
      idle();
      n_tests++;
      if (busy_o !== 3'd3 || err_o !== 1'b0) begin
         n_fail++; $display("[TB] FAIL cycle_freed: got busy=%0d err=%0d, want 3 0", busy_o, err_o);
      end
      core_if.dec_req_valid = 1'b1;
      fab_if.dec_req_ready  = 1'b1;
      #1;
      n_tests++;
      if (fab_if.dec_req_valid !== 1'b1 || fab_if.dec_req.id !== IdT'(2)) begin
         n_fail++;
         $display("[TB] FAIL cycle_realloc: got valid=%0d id=%0d, want 1 2",
                  fab_if.dec_req_valid, fab_if.dec_req.id);
      end
      tick();
      idle();
      n_tests++;
      if (busy_o !== 3'd4) begin
         n_fail++; $display("[TB] FAIL cycle_busy_refill: got %0d, want 4", busy_o);
      end
   endtask

   task automatic test_exe_hold();
      do_reset();
      alloc_n(2);
      core_if.exe_req       = '{id: IdT'(1), data: 32'h0};
      core_if.exe_req_valid = 1'b1;
      fab_if.exe_req_ready  = 1'b1;
      #1;
      n_tests++;
      if (fab_if.exe_req_valid !== 1'b0 || core_if.exe_req_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hold_in_dec: got valid=%0d ready=%0d, want 0 0",
                  fab_if.exe_req_valid, core_if.exe_req_ready);
      end
      tick();
      fab_if.dec_rsp        = '{id: IdT'(1), data: 32'h0};
      fab_if.dec_rsp_valid  = 1'b1;
      core_if.dec_rsp_ready = 1'b1;
      #1;
      n_tests++;
      if (fab_if.exe_req_valid !== 1'b0 || core_if.exe_req_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hold_same_cycle_dec_rsp: got valid=%0d ready=%0d, want 0 0",
                  fab_if.exe_req_valid, core_if.exe_req_ready);
      end
      tick();
      fab_if.dec_rsp_valid  = 1'b0;
      core_if.dec_rsp_ready = 1'b0;
      #1;
      n_tests++;
      if (fab_if.exe_req_valid !== 1'b1 || core_if.exe_req_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL hold_released: got valid=%0d ready=%0d, want 1 1",
                  fab_if.exe_req_valid, core_if.exe_req_ready);
      end
      tick();
      idle();
      n_tests++;
      if (err_o !== 1'b0 || busy_o !== 3'd2) begin
         n_fail++; $display("[TB] FAIL hold_after: got err=%0d busy=%0d, want 0 2", err_o, busy_o);
      end
   endtask

   task automatic test_exe_drop();
      do_reset();
      alloc_n(1);
      core_if.exe_req       = '{id: IdT'(3), data: 32'h0};
      core_if.exe_req_valid = 1'b1;
      fab_if.exe_req_ready  = 1'b0;
      #1;
      n_tests++;
      if (core_if.exe_req_ready !== 1'b1 || fab_if.exe_req_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL drop_free_id: got ready=%0d valid=%0d, want 1 0",
                  core_if.exe_req_ready, fab_if.exe_req_valid);
      end
      tick();
      idle();
      n_tests++;
      if (err_o !== 1'b1 || busy_o !== 3'd1) begin
         n_fail++; $display("[TB] FAIL drop_err_pulse: got err=%0d busy=%0d, want 1 1", err_o, busy_o);
      end
      tick();
      n_tests++;
      if (err_o !== 1'b0) begin
         n_fail++; $display("[TB] FAIL drop_err_single: got %0d, want 0", err_o);
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      alloc_n(4);
      send_dec_rsp(0);
      send_exe_req(0);
      fab_if.exe_rsp        = '{id: IdT'(0), data: 32'h0};
      fab_if.exe_rsp_valid  = 1'b1;
      core_if.exe_rsp_ready = 1'b1;
      core_if.dec_req_valid = 1'b1;
      fab_if.dec_req_ready  = 1'b1;
      #1;
      n_tests++;
      if (core_if.dec_req_ready !== 1'b0 || fab_if.dec_req_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL stall_same_cycle_free: got ready=%0d valid=%0d, want 0 0",
                  core_if.dec_req_ready, fab_if.dec_req_valid);
      end
      tick();
      fab_if.exe_rsp_valid  = 1'b0;
      core_if.exe_rsp_ready = 1'b0;
      #1;
      n_tests++;
      if (busy_o !== 3'd3 || fab_if.dec_req_valid !== 1'b1 || fab_if.dec_req.id !== IdT'(0)) begin
         n_fail++;
         $display("[TB] FAIL stall_then_id0: got busy=%0d valid=%0d id=%0d, want 3 1 0",
                  busy_o, fab_if.dec_req_valid, fab_if.dec_req.id);
      end
      tick();
      idle();
      n_tests++;
      if (busy_o !== 3'd4) begin
         n_fail++; $display("[TB] FAIL stall_busy_refill: got %0d, want 4", busy_o);
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      alloc_n(3);
      n_tests++;
      if (busy_o !== 3'd3) begin
         n_fail++; $display("[TB] FAIL midrst_busy_before: got %0d, want 3", busy_o);
      end
      rst = 1'b1;
      all_inputs_high();
      #1;
      n_tests++;
      if (hs_outs() !== 8'h00) begin
         n_fail++; $display("[TB] FAIL midrst_handshakes: got %b, want 00000000", hs_outs());
      end
      tick();
      n_tests++;
      if (busy_o !== 3'd0) begin
         n_fail++; $display("[TB] FAIL midrst_busy_after: got %0d, want 0", busy_o);
      end
      rst = 1'b0;
      idle();
      core_if.dec_req_valid = 1'b1;
      fab_if.dec_req_ready  = 1'b1;
      #1;
      n_tests++;
      if (fab_if.dec_req_valid !== 1'b1 || fab_if.dec_req.id !== IdT'(0)) begin
         n_fail++;
         $display("[TB] FAIL midrst_first_id: got valid=%0d id=%0d, want 1 0",
                  fab_if.dec_req_valid, fab_if.dec_req.id);
      end
      tick();
      idle();
   endtask

   // Randomized traffic; the model is a table of ID states plus the rules
   // for each channel, with occupancy taken as the count of non-free IDs.
   task automatic test_random();
      int m_st [N];
      int old_st [N];
      int lowest, nbusy, e, est, drsp, ersp, exp_busy;
      bit exp_can, exp_dv, exp_dr, exp_ev, exp_er, exp_err;
      do_reset();
      for (int i = 0; i < N; i++) m_st[i] = M_FREE;
      for (int cyc = 0; cyc < 300; cyc++) begin
         core_if.dec_req       = '{id: IdT'($urandom), data: $urandom};
         core_if.dec_req_valid = 1'($urandom_range(0, 1));
         fab_if.dec_req_ready  = ($urandom_range(0, 3) != 0);
         drsp                  = $urandom_range(0, 4);
         fab_if.dec_rsp        = '{id: IdT'(drsp), data: $urandom};
         fab_if.dec_rsp_valid  = 1'($urandom_range(0, 1));
         core_if.dec_rsp_ready = ($urandom_range(0, 3) != 0);
         e                     = $urandom_range(0, 4);
         core_if.exe_req       = '{id: IdT'(e), data: $urandom};
         core_if.exe_req_valid = 1'($urandom_range(0, 1));
         fab_if.exe_req_ready  = ($urandom_range(0, 3) != 0);
         ersp                  = $urandom_range(0, 4);
         fab_if.exe_rsp        = '{id: IdT'(ersp), data: $urandom};
         fab_if.exe_rsp_valid  = 1'($urandom_range(0, 1));
         core_if.exe_rsp_ready = ($urandom_range(0, 3) != 0);

         lowest = -1;
         nbusy  = 0;
         for (int i = N - 1; i >= 0; i--) begin
            if (m_st[i] == M_FREE) lowest = i;
            else nbusy++;
         end
         exp_can = (lowest >= 0) && (nbusy < N);
         exp_dv  = core_if.dec_req_valid && exp_can;
         exp_dr  = fab_if.dec_req_ready && exp_can;
         est     = (e < N) ? m_st[e] : M_FREE;
         exp_ev  = core_if.exe_req_valid && (est == M_RDY);
         exp_er  = (est == M_RDY) ? fab_if.exe_req_ready : (est == M_FREE);

         #1;
         n_tests++;
         if (fab_if.dec_req_valid !== exp_dv || core_if.dec_req_ready !== exp_dr) begin
            n_fail++;
            $display("[TB] FAIL rand_dec_req c%0d: got v=%0d r=%0d, want %0d %0d", cyc,
                     fab_if.dec_req_valid, core_if.dec_req_ready, exp_dv, exp_dr);
         end
         if (exp_can) begin
            n_tests++;
            if (int'(fab_if.dec_req.id) !== lowest) begin
               n_fail++;
               $display("[TB] FAIL rand_alloc_id c%0d: got %0d, want %0d", cyc,
                        fab_if.dec_req.id, lowest);
            end
         end
         n_tests++;
         if (fab_if.exe_req_valid !== exp_ev || core_if.exe_req_ready !== exp_er) begin
            n_fail++;
            $display("[TB] FAIL rand_exe_req c%0d id%0d: got v=%0d r=%0d, want %0d %0d", cyc, e,
                     fab_if.exe_req_valid, core_if.exe_req_ready, exp_ev, exp_er);
         end
         n_tests++;
         if (core_if.dec_rsp_valid !== fab_if.dec_rsp_valid || fab_if.dec_rsp_ready !== core_if.dec_rsp_ready ||
             core_if.exe_rsp_valid !== fab_if.exe_rsp_valid || fab_if.exe_rsp_ready !== core_if.exe_rsp_ready) begin
            n_fail++;
            $display("[TB] FAIL rand_rsp_pass c%0d: got %b%b%b%b, want %b%b%b%b", cyc,
                     core_if.dec_rsp_valid, fab_if.dec_rsp_ready, core_if.exe_rsp_valid,
                     fab_if.exe_rsp_ready, fab_if.dec_rsp_valid, core_if.dec_rsp_ready,
                     fab_if.exe_rsp_valid, core_if.exe_rsp_ready);
         end

         old_st  = m_st;
         exp_err = 1'b0;
         if (exp_dv && fab_if.dec_req_ready) m_st[lowest] = M_DEC;
         if (fab_if.dec_rsp_valid && core_if.dec_rsp_ready) begin
            if (drsp < N && old_st[drsp] == M_DEC) m_st[drsp] = M_RDY;
            else exp_err = 1'b1;
         end
         if (exp_ev && fab_if.exe_req_ready) m_st[e] = M_EXE;
         if (core_if.exe_req_valid && est == M_FREE) exp_err = 1'b1;
         if (fab_if.exe_rsp_valid && core_if.exe_rsp_ready) begin
            if (ersp < N && old_st[ersp] == M_EXE) m_st[ersp] = M_FREE;
            else exp_err = 1'b1;
         end
         exp_busy = 0;
         for (int i = 0; i < N; i++) if (m_st[i] != M_FREE) exp_busy++;

         tick();
         n_tests++;
         if (int'(busy_o) !== exp_busy || err_o !== exp_err) begin
            n_fail++;
            $display("[TB] FAIL rand_regs c%0d: got busy=%0d err=%0d, want %0d %0d", cyc,
                     busy_o, err_o, exp_busy, exp_err);
         end
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      test_reset();
      test_fill();
      test_full_cycle();
      test_exe_hold();
      test_exe_drop();
      test_full_stall();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
